// File: rtl/memory_pkg.sv
// Shared types and helpers for the data memory responder.
// Holds the FSM state enum, word size and byte-lane helper.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } responder_state_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [1:0] lane_of(input logic [31:0] address);
        return address[1:0];
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte lane handling for the data memory responder.
// Selects and zero-extends load bytes; merges store bytes into a word.
module byte_lane_unit (
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0] shift;

    assign shift = {lane_i, 3'b000};

    // Byte extract for loads and lane overwrite for stores.
    always_comb begin
        load_o = {24'b0, word_i[shift +: 8]};
        merged_o = word_i;
        merged_o[shift +: 8] = byte_i;
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder with internal array and fixed wait states.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned word accesses.
module data_memory_responder
    import memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic        request_write,
    input  logic        request_byte,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        response_valid,
    output logic [31:0] read_data,
    output logic        response_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int IDX_LSB = $clog2(WORD_BYTES);
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic ZERO_WAIT = (WAIT_STATES == 0);

    responder_state_t state_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [31:0]      wdata_q;
    logic             write_q;
    logic             byte_q;
    logic             ready_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             finish;
    logic             in_idle;
    logic [IDX_W-1:0] cur_idx;
    logic [1:0]       cur_lane;
    logic [31:0]      cur_wdata;
    logic             cur_write;
    logic             cur_byte;
    logic             fault;
    logic [31:0]      old_word;
    logic [31:0]      lane_load;
    logic [31:0]      lane_merge;
    logic [31:0]      store_d;
    logic [31:0]      rdata_d;
    logic             mem_we;
    logic             unused_addr;

    assign unused_addr = ^address[31:IDX_LSB+IDX_W];

    assign accept  = request_valid & ready_q;
    assign in_idle = (state_q == IDLE);
    assign finish  = ((state_q == WAIT) && (cnt_q == 4'd0))
                   || (in_idle && accept && ZERO_WAIT);

    // With zero wait states the access completes at the accept edge,
    // so the live request is used instead of the captured copy.
    assign cur_idx   = in_idle ? address[IDX_LSB +: IDX_W] : idx_q;
    assign cur_lane  = in_idle ? lane_of(address) : lane_q;
    assign cur_wdata = in_idle ? write_data : wdata_q;
    assign cur_write = in_idle ? request_write : write_q;
    assign cur_byte  = in_idle ? request_byte : byte_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault = ~cur_byte & (cur_lane != 2'b00);
`else
    assign fault = 1'b0;
`endif

    assign old_word = mem_q[cur_idx];

    byte_lane_unit u_lane (
        .word_i   (old_word),
        .byte_i   (cur_wdata[7:0]),
        .lane_i   (cur_lane),
        .load_o   (lane_load),
        .merged_o (lane_merge)
    );

    assign store_d = cur_byte ? lane_merge : cur_wdata;
    assign rdata_d = (cur_write | fault) ? 32'd0
                   : (cur_byte ? lane_load : old_word);
    assign mem_we  = finish & cur_write & ~fault & ~reset;

    // Array write; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[cur_idx] <= store_d;
        end
    end

    // Responder FSM with request capture and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            lane_q   <= 2'b00;
            wdata_q  <= 32'd0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= address[IDX_LSB +: IDX_W];
                        lane_q  <= lane_of(address);
                        wdata_q <= write_data;
                        write_q <= request_write;
                        byte_q  <= request_byte;
                        ready_q <= 1'b0;
                        if (finish) begin
                            state_q  <= RESPOND;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rdata_d;
                            err_q    <= fault;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= RESPOND;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rdata_d;
                        err_q    <= fault;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESPOND: begin
                    state_q  <= IDLE;
                    ready_q  <= 1'b1;
                    rvalid_q <= 1'b0;
                    rdata_q  <= 32'd0;
                    err_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign request_ready  = ready_q;
    assign response_valid = rvalid_q;
    assign read_data      = rdata_q;
    assign response_error = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder.
// Uses DEPTH_WORDS=64, WAIT_STATES=2.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        request_valid = 1'b0;
    logic        request_ready;
    logic        request_write = 1'b0;
    logic        request_byte = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        response_valid;
    logic [31:0] read_data;
    logic        response_error;

    int n_vec = 0;
    int n_err = 0;

    data_memory_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .request_valid  (request_valid),
        .request_ready  (request_ready),
        .request_write  (request_write),
        .request_byte   (request_byte),
        .address        (address),
        .write_data     (write_data),
        .response_valid (response_valid),
        .read_data      (read_data),
        .response_error (response_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output int lat, output logic ok,
                          output logic rdy_low);
        request_valid = 1'b1;
        request_write = w;
        request_byte  = b;
        address       = a;
        write_data    = d;
        @(posedge clock);
        #1;
        request_valid = 1'b0;
        address       = 32'hFFFF_FFFF;
        write_data    = 32'hFFFF_FFFF;
        request_write = ~w;
        request_byte  = ~b;
        lat     = 1;
        rdy_low = 1'b1;
        while (!response_valid && lat < 20) begin
            if (request_ready) rdy_low = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
        if (request_ready) rdy_low = 1'b0;
        ok = response_valid;
        rd = read_data;
        er = response_error;
        @(posedge clock);
        #1;
        request_write = 1'b0;
        request_byte  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic b,
                           input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic er, ok, rl;
        int lat;
        access(1'b0, b, a, 32'd0, rd, er, lat, ok, rl);
        chk({tag, "_valid"}, {31'd0, ok}, 32'd1);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, {31'd0, er}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic b,
                            input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic er, ok, rl;
        int lat;
        access(1'b1, b, a, d, rd, er, lat, ok, rl);
        chk({tag, "_valid"}, {31'd0, ok}, 32'd1);
        chk({tag, "_data"}, rd, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er, ok, rl;
        int lat;
        int seen;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, request_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, response_valid}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_err", {31'd0, response_error}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        access(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, rd, er, lat, ok, rl);
        chk("st_valid", {31'd0, ok}, 32'd1);
        chk("st_lat", lat, 32'd3);
        chk("st_rdy_low", {31'd0, rl}, 32'd1);
        chk("st_rdata", rd, 32'd0);
        chk("st_idle_ready", {31'd0, request_ready}, 32'd1);
        chk("st_idle_rdata", read_data, 32'd0);

        access(1'b0, 1'b0, 32'h100, 32'd0, rd, er, lat, ok, rl);
        chk("ld_valid", {31'd0, ok}, 32'd1);
        chk("ld_lat", lat, 32'd3);
        chk("ld_rdy_low", {31'd0, rl}, 32'd1);
        chk("ld_data", rd, 32'hDEAD_BEEF);

        do_store("stb", 1'b1, 32'h102, 32'hFFFF_FF55);
        do_load("ldw_merge", 1'b0, 32'h100, 32'hDE55_BEEF);
        do_load("ldb_103", 1'b1, 32'h103, 32'h0000_00DE);
        do_load("ldb_101", 1'b1, 32'h101, 32'h0000_00BE);
        do_load("ldb_100", 1'b1, 32'h100, 32'h0000_00EF);

        do_store("st_wrap", 1'b0, 32'h000, 32'h1234_5678);
        do_load("ld_wrap", 1'b0, 32'h100, 32'h1234_5678);
        do_load("ld_zero", 1'b0, 32'h000, 32'h1234_5678);

        do_store("st_010", 1'b0, 32'h010, 32'h0BAD_F00D);
        request_valid = 1'b1;
        request_write = 1'b1;
        request_byte  = 1'b0;
        address       = 32'h010;
        write_data    = 32'hAAAA_AAAA;
        @(posedge clock);
        #1;
        request_valid = 1'b0;
        request_write = 1'b0;
        reset = 1'b1;
        seen = 0;
        @(posedge clock);
        #1;
        if (response_valid) seen++;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (response_valid) seen++;
        end
        chk("abort_no_resp", seen, 32'd0);
        chk("abort_ready", {31'd0, request_ready}, 32'd1);
        do_load("abort_old", 1'b0, 32'h010, 32'h0BAD_F00D);

`ifdef DMEM_MISALIGN_TRAP_EN
        access(1'b0, 1'b0, 32'h101, 32'd0, rd, er, lat, ok, rl);
        chk("mis_ld_valid", {31'd0, ok}, 32'd1);
        chk("mis_ld_err", {31'd0, er}, 32'd1);
        chk("mis_ld_data", rd, 32'd0);
        chk("mis_ld_lat", lat, 32'd3);
        access(1'b1, 1'b0, 32'h102, 32'hFFFF_FFFF, rd, er, lat, ok, rl);
        chk("mis_st_err", {31'd0, er}, 32'd1);
        do_load("mis_st_none", 1'b0, 32'h100, 32'h1234_5678);
        do_load("mis_byte_ok", 1'b1, 32'h101, 32'h0000_0056);
`else
        do_load("mis_ld", 1'b0, 32'h101, 32'h1234_5678);
        do_store("mis_st", 1'b0, 32'h102, 32'hCAFE_0001);
        do_load("mis_st_al", 1'b0, 32'h100, 32'hCAFE_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
